// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and IMEM write port bundle for the image loader
interface imem_loader_if #(
    parameter int AW = 6
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed, checksummed byte image into IMEM and releases the core
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t      state, next_state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [31:0] word_reg;
    logic [7:0]  csum;
    logic        accept;
    logic        last_word;
    logic [15:0] n_lo;
    logic [31:0] word_next;

    assign accept    = bus.in_valid && bus.in_ready;
    assign n_lo      = {len_hi, bus.in_data};
    assign word_next = {word_reg[23:0], bus.in_data};
    assign last_word = (16'(words_loaded) + 16'd1) == len;

    always_ff @(posedge clk) begin
        if (reset) state <= S_LEN_HI;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        bus.in_ready = 1'b0;
        case (state)
            S_LEN_HI: begin
                bus.in_ready = 1'b1;
                if (accept) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                bus.in_ready = 1'b1;
                if (accept) begin
                    if (n_lo == 16'd0 || n_lo > 16'(DEPTH)) next_state = S_ERR;
                    else                                     next_state = S_DATA;
                end
            end
            S_DATA: begin
                bus.in_ready = 1'b1;
                if (accept && byte_cnt == 2'd3 && last_word) next_state = S_CHECK;
            end
            S_CHECK: begin
                bus.in_ready = 1'b1;
                if (accept) next_state = (bus.in_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE:  next_state = S_DONE;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_LEN_HI;
        endcase
    end

    // Status flags follow next_state so they assert in the first cycle of the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi         <= '0;
            len            <= '0;
            byte_cnt       <= '0;
            word_reg       <= '0;
            csum           <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            words_loaded   <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            cpu_reset   <= (next_state != S_DONE);
            done        <= (next_state == S_DONE);
            error       <= (next_state == S_ERR);
            if (accept) begin
                case (state)
                    S_LEN_HI: len_hi <= bus.in_data;
                    S_LEN_LO: len    <= n_lo;
                    S_DATA: begin
                        word_reg <= word_next;
                        csum     <= csum + bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= words_loaded[AW-1:0];
                            bus.imem_wdata <= word_next;
                            words_loaded   <= words_loaded + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
